// File: rtl/snn_fc_argmax.sv
// Binary-input fully connected layer with argmax over the output neurons.
// Latency: N_OUT*(N_IN+2) cycles from the accepted start to done.
// No backpressure: memories are synchronous; start is ignored while busy.
//
// Ports:
//   clk, rst_n         clock and asynchronous active-low reset
//   start              inference request (accepted in IDLE or DONE)
//   addr_input_unit    address to the 1-bit input RAM, q_input is its read data
//   addr_weight        address to the signed weight ROM, q_weight is its read data
//   digit, max_val     index and accumulator value of the winning neuron
//   busy, done         inference running / result valid (level)
module snn_fc_argmax #(
  parameter int N_IN  = 784,
  parameter int N_OUT = 10,
  parameter int W_W   = 8,
  parameter int ACC_W = 16
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              start,
  output logic [$clog2(N_IN)-1:0]           addr_input_unit,
  input  logic                              q_input,
  output logic [$clog2(N_IN*N_OUT)-1:0]     addr_weight,
  input  logic signed [W_W-1:0]             q_weight,
  output logic [$clog2(N_OUT)-1:0]          digit,
  output logic signed [ACC_W-1:0]           max_val,
  output logic                              busy,
  output logic                              done
);

  localparam int AI_W = $clog2(N_IN);
  localparam int AW_W = $clog2(N_IN*N_OUT);
  localparam int AO_W = $clog2(N_OUT);

  localparam logic [AI_W-1:0] I_LAST = AI_W'(N_IN - 1);
  localparam logic [AO_W-1:0] O_LAST = AO_W'(N_OUT - 1);

  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_MAC,
    S_DRAIN,
    S_CMP,
    S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [AI_W-1:0]         i_cnt;
  logic [AW_W-1:0]         w_cnt;   // running weight address, equals o*N_IN+i in MAC
  logic [AO_W-1:0]         o_cnt;
  logic                    mac_vld; // memory data for last cycle's MAC address is on q_*
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] best_val;
  logic [AO_W-1:0]         best_idx;

  logic signed [ACC_W:0]   acc_sum;
  logic signed [ACC_W-1:0] acc_sat;
  logic                    best_take;
  logic                    accept;

  // One guard bit above the accumulator detects overflow of the add.
  always_comb begin
    acc_sum = (ACC_W+1)'(acc) + (ACC_W+1)'(q_weight);
    acc_sat = acc_sum[ACC_W-1:0];
    if (acc_sum[ACC_W] != acc_sum[ACC_W-1]) begin
      acc_sat = acc_sum[ACC_W] ? ACC_MIN : ACC_MAX;
    end
  end

  // Neuron 0 always seeds best; strict compare keeps the lower index on ties.
  assign best_take = (o_cnt == '0) || (acc > best_val);
  assign accept    = start && ((state == S_IDLE) || (state == S_DONE));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt       = state;
    busy            = 1'b0;
    done            = 1'b0;
    addr_input_unit = '0;
    addr_weight     = '0;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = S_MAC;
      end
      S_MAC: begin
        busy            = 1'b1;
        addr_input_unit = i_cnt;
        addr_weight     = w_cnt;
        if (i_cnt == I_LAST) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        busy      = 1'b1;
        state_nxt = S_CMP;
      end
      S_CMP: begin
        busy      = 1'b1;
        state_nxt = (o_cnt == O_LAST) ? S_DONE : S_MAC;
      end
      S_DONE: begin
        done = 1'b1;
        if (start) state_nxt = S_MAC;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i_cnt    <= '0;
      w_cnt    <= '0;
      o_cnt    <= '0;
      mac_vld  <= 1'b0;
      acc      <= '0;
      best_val <= '0;
      best_idx <= '0;
      digit    <= '0;
      max_val  <= '0;
    end else begin
      mac_vld <= (state == S_MAC);

      // Accumulate the data returned for the previous MAC address (also in DRAIN).
      if (mac_vld && q_input) begin
        acc <= acc_sat;
      end

      if (accept) begin
        i_cnt    <= '0;
        w_cnt    <= '0;
        o_cnt    <= '0;
        acc      <= '0;
        best_val <= '0;
        best_idx <= '0;
      end

      if (state == S_MAC) begin
        i_cnt <= i_cnt + AI_W'(1);
        w_cnt <= w_cnt + AW_W'(1);
      end

      if (state == S_CMP) begin
        acc   <= '0;
        i_cnt <= '0;
        if (best_take) begin
          best_val <= acc;
          best_idx <= o_cnt;
        end
        if (o_cnt != O_LAST) begin
          o_cnt <= o_cnt + AO_W'(1);
        end else begin
          // Result is published from the post-compare best of the last neuron.
          digit   <= best_take ? o_cnt : best_idx;
          max_val <= best_take ? acc : best_val;
        end
      end
    end
  end

endmodule

// File: tb/tb_snn_fc_argmax.sv
module tb_snn_fc_argmax;

  logic clk;
  logic rst_n;

  // Small instance: N_IN=4, N_OUT=3, W_W=8, ACC_W=8
  logic              start;
  logic [1:0]        addr_input_unit;
  logic              q_input;
  logic [3:0]        addr_weight;
  logic signed [7:0] q_weight;
  logic [1:0]        digit;
  logic signed [7:0] max_val;
  logic              busy;
  logic              done;

  // Default-parameter instance
  logic               start_d;
  logic [9:0]         addr_input_unit_d;
  logic               q_input_d;
  logic [12:0]        addr_weight_d;
  logic signed [7:0]  q_weight_d;
  logic [3:0]         digit_d;
  logic signed [15:0] max_val_d;
  logic               busy_d;
  logic               done_d;

  int checks   = 0;
  int failures = 0;

  logic              in_mem [0:3];
  logic signed [7:0] w_mem  [0:11];

  snn_fc_argmax #(.N_IN(4), .N_OUT(3), .W_W(8), .ACC_W(8)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (start),
    .addr_input_unit (addr_input_unit),
    .q_input         (q_input),
    .addr_weight     (addr_weight),
    .q_weight        (q_weight),
    .digit           (digit),
    .max_val         (max_val),
    .busy            (busy),
    .done            (done)
  );

  snn_fc_argmax dut_d (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (start_d),
    .addr_input_unit (addr_input_unit_d),
    .q_input         (q_input_d),
    .addr_weight     (addr_weight_d),
    .q_weight        (q_weight_d),
    .digit           (digit_d),
    .max_val         (max_val_d),
    .busy            (busy_d),
    .done            (done_d)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous memories: one cycle read latency.
  always @(posedge clk) begin
    q_input  <= in_mem[addr_input_unit];
    q_weight <= w_mem[addr_weight];
    // Default instance: all inputs 0, arbitrary weights from the address.
    q_input_d  <= (addr_input_unit_d == 10'h3ff);
    q_weight_d <= addr_weight_d[7:0];
  end

  task automatic load(input logic [3:0] ins, input logic signed [7:0] w [0:11]);
    for (int k = 0; k < 4; k++) in_mem[k] = ins[k];
    for (int k = 0; k < 12; k++) w_mem[k] = w[k];
  endtask

  // One inference on the small instance with timing, address and result checks.
  task automatic run_small(input string name, input int pulse_at,
                           input logic [1:0] exp_digit, input logic signed [7:0] exp_max,
                           input logic [1:0] prev_digit, input logic signed [7:0] prev_max);
    int n;
    int busy_cnt;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    checks++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL %s start_accept: done=%b busy=%b required done=0 busy=1", name, done, busy);
    end
    busy_cnt = busy ? 1 : 0;
    n = 0;
    while (done !== 1'b1 && n < 100) begin
      @(posedge clk);
      n++;
      #1;
      start = (n == pulse_at);
      if (n == 4) begin
        checks++;
        if (addr_input_unit !== 2'd0 || addr_weight !== 4'd0) begin
          failures++;
          $display("FAIL %s drain_addr: in=%0d w=%0d required 0 0", name, addr_input_unit, addr_weight);
        end
      end
      if (n == 7) begin
        checks++;
        if (addr_input_unit !== 2'd1 || addr_weight !== 4'd5) begin
          failures++;
          $display("FAIL %s mac_addr: in=%0d w=%0d required 1 5", name, addr_input_unit, addr_weight);
        end
      end
      if (n == 9) begin
        checks++;
        if (digit !== prev_digit || max_val !== prev_max) begin
          failures++;
          $display("FAIL %s held_result: digit=%0d max=%0d required %0d %0d",
                   name, digit, max_val, prev_digit, prev_max);
        end
      end
      if (busy === 1'b1) busy_cnt++;
    end
    start = 1'b0;
    checks++;
    if (n != 18) begin
      failures++;
      $display("FAIL %s done_latency: edges=%0d required 18", name, n);
    end
    checks++;
    if (busy_cnt != 18) begin
      failures++;
      $display("FAIL %s busy_cycles: got=%0d required 18", name, busy_cnt);
    end
    checks++;
    if (digit !== exp_digit) begin
      failures++;
      $display("FAIL %s digit: got=%0d required %0d", name, digit, exp_digit);
    end
    checks++;
    if (max_val !== exp_max) begin
      failures++;
      $display("FAIL %s max_val: got=%0d required %0d", name, max_val, exp_max);
    end
  endtask

  task automatic load_basic();
    logic signed [7:0] w [0:11];
    w = '{8'sd1, 8'sd2, 8'sd3, 8'sd4, -8'sd1, 8'sd50, 8'sd2, 8'sd2, 8'sd5, 8'sd5, 8'sd5, 8'sd5};
    load(4'b1101, w); // inputs {1,0,1,1}, bit k = unit k
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    start_d = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || digit !== 2'd0 || max_val !== 8'sd0 ||
        addr_input_unit !== 2'd0 || addr_weight !== 4'd0) begin
      failures++;
      $display("FAIL reset_state: busy=%b done=%b digit=%0d max=%0d ain=%0d aw=%0d required all 0",
               busy, done, digit, max_val, addr_input_unit, addr_weight);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || busy_d !== 1'b0 || done_d !== 1'b0) begin
      failures++;
      $display("FAIL idle_after_reset: busy=%b done=%b busy_d=%b done_d=%b required 0",
               busy, done, busy_d, done_d);
    end
  endtask

  task automatic test_basic();
    load_basic();
    run_small("basic", -1, 2'd2, 8'sd15, 2'd0, 8'sd0);
  endtask

  task automatic test_start_ignored();
    // Starts from DONE of the previous run; extra pulse lands in neuron 1's MAC.
    run_small("start_ignored", 8, 2'd2, 8'sd15, 2'd2, 8'sd15);
  endtask

  task automatic test_tie();
    logic signed [7:0] w [0:11];
    for (int k = 0; k < 12; k++) w[k] = 8'sd7;
    load(4'b1111, w);
    run_small("tie", -1, 2'd0, 8'sd28, 2'd2, 8'sd15);
  endtask

  task automatic test_saturation();
    logic signed [7:0] w [0:11];
    for (int k = 0; k < 4; k++) begin
      w[k]     = 8'sd100;
      w[k + 4] = -8'sd100;
      w[k + 8] = 8'sd0;
    end
    load(4'b1111, w);
    run_small("saturation", -1, 2'd0, 8'sd127, 2'd0, 8'sd28);
  endtask

  task automatic test_reset_mid_mac();
    load_basic();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL midmac_reset_flags: busy=%b done=%b required 0 0", busy, done);
    end
    checks++;
    if (digit !== 2'd0 || max_val !== 8'sd0) begin
      failures++;
      $display("FAIL midmac_reset_result: digit=%0d max=%0d required 0 0", digit, max_val);
    end
    checks++;
    if (addr_input_unit !== 2'd0 || addr_weight !== 4'd0) begin
      failures++;
      $display("FAIL midmac_reset_addr: ain=%0d aw=%0d required 0 0", addr_input_unit, addr_weight);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_small("after_reset", -1, 2'd2, 8'sd15, 2'd0, 8'sd0);
  endtask

  task automatic test_default_params();
    int n;
    @(negedge clk);
    start_d = 1'b1;
    @(posedge clk);
    #1;
    start_d = 1'b0;
    n = 0;
    while (done_d !== 1'b1 && n < 9000) begin
      @(posedge clk);
      n++;
      #1;
    end
    checks++;
    if (n != 7860) begin
      failures++;
      $display("FAIL default_latency: edges=%0d required 7860", n);
    end
    checks++;
    if (digit_d !== 4'd0 || max_val_d !== 16'sd0) begin
      failures++;
      $display("FAIL default_result: digit=%0d max=%0d required 0 0", digit_d, max_val_d);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_start_ignored();
    test_tie();
    test_saturation();
    test_reset_mid_mac();
    test_default_params();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/snn_fc_argmax.md
SNN_FC_ARGMAX -- requirements
Module: snn_fc_argmax

Interface
REQ-001 SHALL have parameter N_IN, default 784: number of binary input units per inference.
REQ-002 SHALL have parameter N_OUT, default 10: number of output neurons (classes), minimum 2.
REQ-003 SHALL have parameter W_W, default 8: signed weight width.
REQ-004 SHALL have parameter ACC_W, default 16: signed accumulator width, ACC_W >= W_W.
REQ-005 SHALL have port clk  in  1  the single clock, rising-edge active.
REQ-006 SHALL have port rst_n  in  1  asynchronous active-low reset.
REQ-007 SHALL have port start  in  1  inference request, sampled on rising clk.
REQ-008 SHALL have port addr_input_unit  out  clog2(N_IN)  address to external 1-bit input RAM.
REQ-009 SHALL have port q_input  in  1  input RAM read data.
REQ-010 SHALL have port addr_weight  out  clog2(N_IN*N_OUT)  address to external weight ROM.
REQ-011 SHALL have port q_weight  in  W_W  signed weight ROM read data.
REQ-012 SHALL have port digit  out  clog2(N_OUT)  index of winning neuron.
REQ-013 SHALL have port max_val  out  ACC_W  signed accumulator value of winning neuron.
REQ-014 SHALL have port busy  out  1  inference in progress.
REQ-015 SHALL have port done  out  1  result valid, level.

Function
REQ-016 SHALL treat both memories as synchronous: data for an address driven in cycle k is valid in cycle k+1.
REQ-017 SHALL implement states IDLE, MAC, DRAIN, CMP, DONE.
REQ-018 SHALL in IDLE or DONE, on start=1, clear best-so-far, set neuron index o=0, input index i=0, enter MAC; start in MAC/DRAIN/CMP SHALL be ignored.
REQ-019 SHALL in MAC drive addr_input_unit=i and addr_weight=o*N_IN+i for N_IN consecutive cycles, i=0..N_IN-1, then enter DRAIN.
REQ-020 SHALL, one cycle after each MAC address cycle (including DRAIN), add sign-extended q_weight to acc when q_input=1, else hold acc.
REQ-021 SHALL saturate acc at +(2^(ACC_W-1)-1) and -(2^(ACC_W-1)); no wrap-around.
REQ-022 SHALL go DRAIN -> CMP unconditionally, one cycle.
REQ-023 SHALL in CMP replace best (value, index) when acc > best value, or unconditionally when o=0; ties keep the lower index.
REQ-024 SHALL in CMP clear acc to 0; if o<N_OUT-1, increment o, reset i=0, enter MAC; else enter DONE.
REQ-025 SHALL per neuron take N_IN+2 cycles; done SHALL rise N_OUT*(N_IN+2) clock edges after the edge that sampled start.
REQ-026 SHALL register digit and max_val from best on CMP->DONE, and hold them until next accepted start.
REQ-027 SHALL assert busy in MAC, DRAIN, CMP; deassert in IDLE, DONE.
REQ-028 SHALL hold done=1 in DONE; done SHALL fall the cycle after a start is accepted.
REQ-029 SHALL drive both address outputs to 0 outside MAC.
REQ-030 SHALL keep digit/max_val stable while busy (previous result or reset value).

Reset
REQ-031 SHALL on rst_n=0 immediately force IDLE, acc=0, best cleared, digit=0, max_val=0, busy=0, done=0, addresses=0, regardless of state.
REQ-032 SHALL after reset release accept start on the first rising edge where rst_n=1 and start=1.

Verification (N_IN=4, N_OUT=3, W_W=8, ACC_W=8 unless stated)
REQ-033 SHALL cover: reset asserted mid-MAC -> all outputs 0 same cycle, IDLE; new start then completes normally.
REQ-034 SHALL cover: inputs {1,0,1,1}, weights n0 {1,2,3,4}, n1 {-1,50,2,2}, n2 {5,5,5,5} -> digit=2, max_val=15, done rises 18 edges after start edge, busy high 18 cycles.
REQ-035 SHALL cover: all weights 7, inputs all 1 -> tie, digit=0, max_val=28.
REQ-036 SHALL cover: inputs all 1, n0 weights all 100, n1 all -100, n2 all 0 -> n0 saturates 127, n1 -128; digit=0, max_val=127.
REQ-037 SHALL cover: start pulsed during MAC of neuron 1 -> ignored, result and timing identical to REQ-034; start in DONE -> done falls next cycle, rerun gives same result.
REQ-038 SHALL cover: default parameters with all inputs 0 -> every neuron 0, digit=0, max_val=0, done after 10*786=7860 edges.
